// File: rtl/uart_rx_if.sv
// Serial input and received-byte outputs of the host-link UART receiver.
// The master side is the receiver itself; the slave side is whoever drives
// the serial line and consumes the received bytes.
interface uart_rx_if;
  logic       i_Rx_Serial;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Active;
  logic       o_Rx_Frame_Err;

  modport master (
    input  i_Rx_Serial,
    output o_Rx_DV,
    output o_Rx_Byte,
    output o_Rx_Active,
    output o_Rx_Frame_Err
  );

  modport slave (
    output i_Rx_Serial,
    input  o_Rx_DV,
    input  o_Rx_Byte,
    input  o_Rx_Active,
    input  o_Rx_Frame_Err
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, 1 start, 1 stop, no parity, LSB first.
// Two-flop input synchroniser, mid-bit sampling, start-bit glitch rejection,
// framing-error pulse and break handling (one error per held-low line).
module uart_rx #(
  parameter int CLKS_PER_BIT    = 868,
  parameter int CLK_COUNTER_BIS = 10
) (
  input logic       i_Clock,
  input logic       i_Reset,
  uart_rx_if.master rx_if
);

  localparam logic [CLK_COUNTER_BIS-1:0] CNT_LAST = CLK_COUNTER_BIS'(CLKS_PER_BIT - 1);
  localparam logic [CLK_COUNTER_BIS-1:0] CNT_HALF = CLK_COUNTER_BIS'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CLK_COUNTER_BIS-1:0] CNT_ONE  = CLK_COUNTER_BIS'(1);
  localparam logic [CLK_COUNTER_BIS-1:0] CNT_ZERO = CLK_COUNTER_BIS'(0);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_START      = 3'd1,
    S_DATA       = 3'd2,
    S_STOP       = 3'd3,
    S_CLEANUP    = 3'd4,
    S_BREAK_WAIT = 3'd5
  } state_e;

  state_e                     state_q, state_d;
  logic [CLK_COUNTER_BIS-1:0] cnt_q, cnt_d;
  logic [2:0]                 idx_q, idx_d;
  logic [7:0]                 shift_q, shift_d;
  logic [7:0]                 byte_q, byte_d;
  logic                       dv_q, dv_d;
  logic                       fe_q, fe_d;
  logic                       active_q, active_d;
  logic                       sync1_q, sync1_d;
  logic                       sync2_q, sync2_d;
  logic                       rx_s;

  assign rx_s = sync2_q;

  assign rx_if.o_Rx_DV        = dv_q;
  assign rx_if.o_Rx_Byte      = byte_q;
  assign rx_if.o_Rx_Active    = active_q;
  assign rx_if.o_Rx_Frame_Err = fe_q;

  // Next value of the two-stage synchroniser on the asynchronous line.
  always_comb begin
    sync1_d = rx_if.i_Rx_Serial;
    sync2_d = sync1_q;
  end

  // Receive FSM: bit timing, sampling, byte assembly and output pulses.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    dv_d     = 1'b0;
    fe_d     = 1'b0;
    active_d = active_q;

    case (state_q)
      S_IDLE: begin
        cnt_d    = CNT_ZERO;
        idx_d    = 3'd0;
        active_d = 1'b0;
        if (rx_s == 1'b0) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = CNT_ZERO;
          if (rx_s == 1'b0) begin
            active_d = 1'b1;
            state_d  = S_DATA;
          end else begin
            // Start bit gone by mid-bit: treat as line noise.
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = CNT_ZERO;
          shift_d[idx_q] = rx_s;
          if (idx_q == 3'd7) begin
            idx_d   = 3'd0;
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d    = CNT_ZERO;
          // Drop active together with the result so it is already low in
          // CLEANUP / BREAK_WAIT.
          active_d = 1'b0;
          if (rx_s == 1'b1) begin
            byte_d  = shift_q;
            dv_d    = 1'b1;
            state_d = S_CLEANUP;
          end else begin
            fe_d    = 1'b1;
            state_d = S_BREAK_WAIT;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_CLEANUP: begin
        active_d = 1'b0;
        state_d  = S_IDLE;
      end

      S_BREAK_WAIT: begin
        // Wait out a held-low line so a break reports only one error.
        active_d = 1'b0;
        if (rx_s == 1'b1) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BREAK_WAIT;
        end
      end

      default: begin
        state_d  = S_IDLE;
        cnt_d    = CNT_ZERO;
        idx_d    = 3'd0;
        active_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      state_q  <= S_IDLE;
      cnt_q    <= CNT_ZERO;
      idx_q    <= 3'd0;
      shift_q  <= 8'h00;
      byte_q   <= 8'h00;
      dv_q     <= 1'b0;
      fe_q     <= 1'b0;
      active_q <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      dv_q     <= dv_d;
      fe_q     <= fe_d;
      active_q <= active_d;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

  localparam int CPB = 16;

  logic clk;
  logic rst;
  int   cyc;
  int   errors;
  int   checks;

  // Monitor state, updated on the falling clock edge.
  int         dv_count;
  int         fe_count;
  int         act_count;
  int         both_count;
  int         last_dv_cyc;
  logic       act_at_dv;
  logic [7:0] dv_bytes[$];

  uart_rx_if rx_if ();

  uart_rx #(
    .CLKS_PER_BIT   (CPB),
    .CLK_COUNTER_BIS(5)
  ) dut (
    .i_Clock(clk),
    .i_Reset(rst),
    .rx_if  (rx_if)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running cycle counter.
  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  // Observe DUT outputs away from the active edge.
  always @(negedge clk) begin
    if (rx_if.o_Rx_DV) begin
      dv_count    <= dv_count + 1;
      last_dv_cyc <= cyc;
      act_at_dv   <= rx_if.o_Rx_Active;
      dv_bytes.push_back(rx_if.o_Rx_Byte);
    end
    if (rx_if.o_Rx_Frame_Err) fe_count <= fe_count + 1;
    if (rx_if.o_Rx_Active) act_count <= act_count + 1;
    if (rx_if.o_Rx_DV && rx_if.o_Rx_Frame_Err) both_count <= both_count + 1;
  end

  // Drive one frame starting at the current falling edge.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int clks);
    logic [9:0] bits;
    bits = {stop_bit, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rx_if.i_Rx_Serial = bits[b];
      repeat (clks) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    rx_if.i_Rx_Serial = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_if.i_Rx_Serial = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rx_if.o_Rx_DV !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b expected 0", rx_if.o_Rx_DV); end
    checks++; if (rx_if.o_Rx_Byte !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h expected 00", rx_if.o_Rx_Byte); end
    checks++; if (rx_if.o_Rx_Active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", rx_if.o_Rx_Active); end
    checks++; if (rx_if.o_Rx_Frame_Err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", rx_if.o_Rx_Frame_Err); end
    rst = 1'b0;
    idle(10);
    checks++; if (dv_count !== 0) begin errors++; $display("FAIL idle_no_dv: got %0d expected 0", dv_count); end
  endtask

  task automatic test_basic();
    int dv0, fe0, act0, start_cyc;
    dv0 = dv_count; fe0 = fe_count; act0 = act_count;
    start_cyc = cyc;
    send_frame(8'hA5, 1'b1, CPB);
    idle(20);
    checks++; if (rx_if.o_Rx_Byte !== 8'hA5) begin errors++; $display("FAIL basic_byte: got %h expected a5", rx_if.o_Rx_Byte); end
    checks++; if (dv_count - dv0 !== 1) begin errors++; $display("FAIL basic_dv_count: got %0d expected 1", dv_count - dv0); end
    checks++; if (last_dv_cyc - start_cyc !== 155) begin errors++; $display("FAIL basic_dv_latency: got %0d expected 155", last_dv_cyc - start_cyc); end
    checks++; if (fe_count - fe0 !== 0) begin errors++; $display("FAIL basic_no_ferr: got %0d expected 0", fe_count - fe0); end
    checks++; if (act_at_dv !== 1'b0) begin errors++; $display("FAIL basic_active_cleanup: got %b expected 0", act_at_dv); end
    checks++; if (act_count - act0 !== 144) begin errors++; $display("FAIL basic_active_len: got %0d expected 144", act_count - act0); end
  endtask

  task automatic test_back_to_back();
    int dv0, fe0;
    dv0 = dv_count; fe0 = fe_count;
    dv_bytes.delete();
    send_frame(8'h00, 1'b1, CPB);
    send_frame(8'hFF, 1'b1, CPB);
    send_frame(8'h3C, 1'b1, CPB);
    idle(20);
    checks++; if (dv_count - dv0 !== 3) begin errors++; $display("FAIL b2b_dv_count: got %0d expected 3", dv_count - dv0); end
    checks++; if (fe_count - fe0 !== 0) begin errors++; $display("FAIL b2b_no_ferr: got %0d expected 0", fe_count - fe0); end
    if (dv_bytes.size() == 3) begin
      checks++; if (dv_bytes[0] !== 8'h00) begin errors++; $display("FAIL b2b_byte0: got %h expected 00", dv_bytes[0]); end
      checks++; if (dv_bytes[1] !== 8'hFF) begin errors++; $display("FAIL b2b_byte1: got %h expected ff", dv_bytes[1]); end
      checks++; if (dv_bytes[2] !== 8'h3C) begin errors++; $display("FAIL b2b_byte2: got %h expected 3c", dv_bytes[2]); end
    end
  endtask

  task automatic test_glitch();
    int dv0, fe0, act0;
    dv0 = dv_count; fe0 = fe_count; act0 = act_count;
    rx_if.i_Rx_Serial = 1'b0;
    repeat (5) @(negedge clk);
    idle(40);
    checks++; if (dv_count - dv0 !== 0) begin errors++; $display("FAIL glitch_no_dv: got %0d expected 0", dv_count - dv0); end
    checks++; if (fe_count - fe0 !== 0) begin errors++; $display("FAIL glitch_no_ferr: got %0d expected 0", fe_count - fe0); end
    checks++; if (act_count - act0 !== 0) begin errors++; $display("FAIL glitch_no_active: got %0d expected 0", act_count - act0); end
  endtask

  task automatic test_break();
    int dv0, fe0;
    dv0 = dv_count; fe0 = fe_count;
    send_frame(8'h55, 1'b0, CPB);
    rx_if.i_Rx_Serial = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    idle(3 * CPB);
    checks++; if (fe_count - fe0 !== 1) begin errors++; $display("FAIL break_one_ferr: got %0d expected 1", fe_count - fe0); end
    checks++; if (dv_count - dv0 !== 0) begin errors++; $display("FAIL break_no_dv: got %0d expected 0", dv_count - dv0); end
    checks++; if (rx_if.o_Rx_Byte !== 8'h3C) begin errors++; $display("FAIL break_byte_held: got %h expected 3c", rx_if.o_Rx_Byte); end
    send_frame(8'h81, 1'b1, CPB);
    idle(20);
    checks++; if (rx_if.o_Rx_Byte !== 8'h81) begin errors++; $display("FAIL after_break_byte: got %h expected 81", rx_if.o_Rx_Byte); end
    checks++; if (dv_count - dv0 !== 1) begin errors++; $display("FAIL after_break_dv: got %0d expected 1", dv_count - dv0); end
    checks++; if (fe_count - fe0 !== 1) begin errors++; $display("FAIL after_break_ferr: got %0d expected 1", fe_count - fe0); end
  endtask

  task automatic test_reset_mid_frame();
    int dv0, fe0;
    logic [9:0] bits;
    // Data bits 4..7 and the stop bit are 1, so the line stays idle after reset.
    bits = {1'b1, 8'hF0, 1'b0};
    dv0 = dv_count; fe0 = fe_count;
    for (int b = 0; b < 10; b++) begin
      rx_if.i_Rx_Serial = bits[b];
      if (b == 5) begin
        repeat (CPB / 2) @(negedge clk);
        checks++; if (rx_if.o_Rx_Active !== 1'b1) begin errors++; $display("FAIL midframe_active: got %b expected 1", rx_if.o_Rx_Active); end
        rst = 1'b1;
        #1;
        checks++; if (rx_if.o_Rx_Active !== 1'b0) begin errors++; $display("FAIL async_reset_active: got %b expected 0", rx_if.o_Rx_Active); end
        checks++; if (rx_if.o_Rx_Byte !== 8'h00) begin errors++; $display("FAIL async_reset_byte: got %h expected 00", rx_if.o_Rx_Byte); end
        checks++; if (rx_if.o_Rx_DV !== 1'b0) begin errors++; $display("FAIL async_reset_dv: got %b expected 0", rx_if.o_Rx_DV); end
        @(negedge clk);
        rst = 1'b0;
        repeat (CPB / 2 - 1) @(negedge clk);
      end else begin
        repeat (CPB) @(negedge clk);
      end
    end
    idle(40);
    checks++; if (dv_count - dv0 !== 0) begin errors++; $display("FAIL reset_frame_no_dv: got %0d expected 0", dv_count - dv0); end
    send_frame(8'h7E, 1'b1, CPB);
    idle(20);
    checks++; if (rx_if.o_Rx_Byte !== 8'h7E) begin errors++; $display("FAIL post_reset_byte: got %h expected 7e", rx_if.o_Rx_Byte); end
    checks++; if (dv_count - dv0 !== 1) begin errors++; $display("FAIL post_reset_dv: got %0d expected 1", dv_count - dv0); end
    checks++; if (fe_count - fe0 !== 0) begin errors++; $display("FAIL post_reset_ferr: got %0d expected 0", fe_count - fe0); end
  endtask

  task automatic test_rate_tolerance();
    int dv0, fe0;
    dv0 = dv_count; fe0 = fe_count;
    send_frame(8'hC3, 1'b1, CPB + 1);
    idle(30);
    checks++; if (rx_if.o_Rx_Byte !== 8'hC3) begin errors++; $display("FAIL slow_byte: got %h expected c3", rx_if.o_Rx_Byte); end
    checks++; if (dv_count - dv0 !== 1) begin errors++; $display("FAIL slow_dv: got %0d expected 1", dv_count - dv0); end
    send_frame(8'h00, 1'b1, CPB);
    idle(30);
    send_frame(8'hC3, 1'b1, CPB - 1);
    idle(30);
    checks++; if (rx_if.o_Rx_Byte !== 8'hC3) begin errors++; $display("FAIL fast_byte: got %h expected c3", rx_if.o_Rx_Byte); end
    checks++; if (dv_count - dv0 !== 3) begin errors++; $display("FAIL fast_dv: got %0d expected 3", dv_count - dv0); end
    checks++; if (fe_count - fe0 !== 0) begin errors++; $display("FAIL rate_no_ferr: got %0d expected 0", fe_count - fe0); end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    cyc        = 0;
    dv_count   = 0;
    fe_count   = 0;
    act_count  = 0;
    both_count = 0;
    last_dv_cyc = 0;
    act_at_dv  = 1'b0;
    rst        = 1'b1;
    rx_if.i_Rx_Serial = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_break();
    test_reset_mid_frame();
    test_rate_tolerance();
    checks++; if (both_count !== 0) begin errors++; $display("FAIL dv_ferr_exclusive: got %0d expected 0", both_count); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
